// File: rtl/serial_xnor_correlator.sv
// Bit-serial word correlator: xnor-compares two LSB-first streams
// and reports match count, equality and threshold over WIDTH bits.

module xnorgate (
  input  logic a,
  input  logic b,
  output logic y
);

  // y is high when both inputs agree
  assign y = ~(a ^ b);

endmodule

module serial_xnor_correlator #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 4,
  parameter int THRESH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             eq,
  output logic             ge_thresh
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESH);

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt_next;
  logic             y;

  xnorgate u_xnor (
    .a(a),
    .b(b),
    .y(y)
  );

  // Running count including the bit pair presented this cycle
  assign cnt_next = run_cnt + {{(CNT_W-1){1'b0}}, y};

  // Word sequencer with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      eq        <= 1'b0;
      ge_thresh <= 1'b0;
      run_cnt   <= '0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            run_cnt <= '0;
            idx     <= '0;
          end
        end
        SHIFT: begin
          if (valid_in) begin
            run_cnt <= cnt_next;
            idx     <= idx + 1'b1;
            if (idx == LAST) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              match_cnt <= cnt_next;
              eq        <= (cnt_next == FULL);
              ge_thresh <= (cnt_next >= LIMIT);
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            run_cnt <= '0;
            idx     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xnor_correlator.sv
// Directed bench for serial_xnor_correlator (WIDTH=8, THRESH=6).
// Expected results are hand-computed per word pair.

module tb_serial_xnor_correlator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid_in;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic [3:0] match_cnt;
  logic       eq;
  logic       ge_thresh;

  int total = 0;
  int bad   = 0;

  serial_xnor_correlator #(
    .WIDTH(8),
    .CNT_W(4),
    .THRESH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .valid_in(valid_in),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .match_cnt(match_cnt),
    .eq(eq),
    .ge_thresh(ge_thresh)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary (timeout)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int c, input int e,
                         input int g);
    chk({tag, "_cnt"}, int'(match_cnt), c);
    chk({tag, "_eq"}, int'(eq), e);
    chk({tag, "_ge"}, int'(ge_thresh), g);
  endtask

  // Feeds one word; done must rise exactly after the 8th accepted bit
  task automatic run_word(input logic [7:0] aw, input logic [7:0] bw,
                          input int stall_at, input int stall_n,
                          input int pulse_at, input int prev);
    start    = 1'b1;
    valid_in = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          valid_in = 1'b0;
          a        = 1'b1;
          b        = 1'b1;
          tick();
          chk("stall_busy", int'(busy), 1);
          chk("stall_done", int'(done), 0);
        end
      end
      valid_in = 1'b1;
      a        = aw[i];
      b        = bw[i];
      start    = (i == pulse_at);
      tick();
      start = 1'b0;
      if (i < 7) begin
        chk("bit_done", int'(done), 0);
        chk("bit_busy", int'(busy), 1);
        chk("bit_hold", int'(match_cnt), prev);
      end else begin
        chk("last_done", int'(done), 1);
        chk("last_busy", int'(busy), 0);
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_res("rst", 0, 0, 0);

    run_word(8'hA5, 8'hA5, -1, 0, -1, 0);
    chk_res("a5", 8, 1, 1);
    tick();
    chk("a5_pulse", int'(done), 0);
    chk("a5_idle", int'(busy), 0);
    chk_res("a5_held", 8, 1, 1);

    run_word(8'hFF, 8'h0F, -1, 0, -1, 8);
    chk_res("ff0f", 4, 0, 0);
    tick();

    run_word(8'hFF, 8'h3F, -1, 0, -1, 4);
    chk_res("ff3f", 6, 0, 1);
    tick();

    run_word(8'h5A, 8'h5A, 3, 3, -1, 6);
    chk_res("stall", 8, 1, 1);
    tick();

    start    = 1'b1;
    valid_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      a        = 1'b0;
      b        = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    rst      = 1'b1;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk_res("abort", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", int'(done), 0);
    end
    run_word(8'h3C, 8'h3C, -1, 0, -1, 0);
    chk_res("after_abort", 8, 1, 1);

    run_word(8'hFF, 8'h3F, -1, 0, 3, 8);
    chk_res("b2b_first", 6, 0, 1);
    run_word(8'h00, 8'hFF, -1, 0, -1, 6);
    chk_res("b2b_second", 0, 0, 0);
    tick();
    chk("b2b_pulse", int'(done), 0);
    chk_res("b2b_held", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
